pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Combines three hazard sources into one consistent set of stage-register enables, bubble controls and flush controls:
  - load-use data hazards (ID vs EX);
  - taken-branch control hazards (resolved in EX);
  - multi-cycle data-memory accesses (MEM stage, ready/valid style).
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC register, and drives all of their write enables.
- Keeps saturating stall and flush counters for performance analysis.

Parameters:
- CNT_W, 16, width of the stallCount and flushCount performance counters.
- TIMEOUT, 64, maximum number of cycles spent in MEM_WAIT before memError is raised. Must be ≥ 1.
- TO_W, 7, width of the wait counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_EXmemRead  in  1  instruction in EX is a load.
- ID_EXrd  in  5  destination register of the instruction in EX.
- IF_IDrs1  in  5  rs1 of the instruction in ID.
- IF_IDrs2  in  5  rs2 of the instruction in ID.
- branchTaken  in  1  branch/jump in EX is resolved taken.
- EX_MEMmemAccess  in  1  instruction in MEM performs a load or store.
- dmemReady  in  1  data memory completes the access this cycle.
- PCwrite  out  1  PC register enable.
- IF_IDwrite  out  1  IF/ID register enable.
- IF_IDflush  out  1  replace IF/ID contents with a NOP.
- ID_EXwrite  out  1  ID/EX register enable.
- ID_EXbubble  out  1  zero all control fields latched into ID/EX.
- EX_MEMwrite  out  1  EX/MEM register enable.
- MEM_WBwrite  out  1  MEM/WB register enable.
- memError  out  1  sticky flag: a data-memory access timed out.
- stallCount  out  CNT_W  cycles with PCwrite=0; saturating.
- flushCount  out  CNT_W  cycles with IF_IDflush=1; saturating.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=RUN, waitCnt=0, memError=0, stallCount=0, flushCount=0.
  - Enables follow the RUN equations (all stage enables 1 when no hazard is present).
- States: RUN, MEM_WAIT. The registered state and waitCnt update on the clk rising edge. Outputs are combinational from state and inputs (Mealy), so a hazard acts in the cycle it appears.
- Load-use term: loadUse = ID_EXmemRead & (ID_EXrd != 0) & ((ID_EXrd == IF_IDrs1) | (ID_EXrd == IF_IDrs2)). x0 never causes a stall.
- memWait term: memWait = EX_MEMmemAccess & ~dmemReady.
- Output priority, highest first:
  - memWait:
    - PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite and MEM_WBwrite all 0.
    - IF_IDflush=0, ID_EXbubble=0.
    - The whole pipeline freezes. branchTaken and loadUse are ignored and stay pending, because the EX/ID contents are held.
  - branchTaken:
    - PCwrite=1 (PC loads the target), IF_IDflush=1, ID_EXbubble=1.
    - All other enables 1.
    - loadUse is ignored because the ID instruction is squashed.
  - loadUse:
    - PCwrite=0, IF_IDwrite=0, ID_EXbubble=1.
    - ID_EXwrite, EX_MEMwrite and MEM_WBwrite = 1.
    - Lasts exactly one cycle, because the load advances to MEM.
  - None of the above: all enables 1, IF_IDflush=0, ID_EXbubble=0.
- Transitions:
  - RUN → MEM_WAIT when memWait, with waitCnt←1.
  - MEM_WAIT → RUN on a cycle with dmemReady=1. The pipeline is released in that same cycle, and waitCnt←0.
  - In MEM_WAIT with dmemReady=0, waitCnt increments.
  - When waitCnt == TIMEOUT and dmemReady=0:
    - memError←1 (sticky until reset);
    - that cycle force-releases the pipeline with RUN equations (memWait treated as 0);
    - next state RUN, waitCnt←0.
  - If EX_MEMmemAccess drops while in MEM_WAIT: treat it as a completion, release and return to RUN.
- Counters:
  - stallCount increments on every cycle with PCwrite=0.
  - flushCount increments on every cycle with IF_IDflush=1.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - memWait and branchTaken together: freeze first, then flush on the release cycle.
  - loadUse and branchTaken together: flush wins and stallCount is not incremented.
- Reset mid-MEM_WAIT: immediate return to RUN. The counters and memError clear.

Decomposition:
- Shared pipeline package (pipe_pkg) holds:
  - state encoding constants ST_RUN=1'b0, ST_MEM_WAIT=1'b1;
  - REG_ZERO=5'd0;
  - the CNT_W default.
- Sub-module sat_counter (parameter W; ports clk, rst_n, inc, count) is instantiated twice, for stallCount and flushCount.
- The hazard comparison stays inline.

Test Plan:
- Load-use: ID_EXmemRead=1, ID_EXrd=5, IF_IDrs2=5 for one cycle → PCwrite=0, IF_IDwrite=0, ID_EXbubble=1 for exactly 1 cycle; stallCount 0→1.
- x0 and no-match: ID_EXmemRead=1 with ID_EXrd=0=IF_IDrs1, then with ID_EXrd=7 vs rs1=3/rs2=4 → no stall; all enables 1.
- Branch vs load-use: branchTaken=1 while the load-use condition holds → IF_IDflush=1, ID_EXbubble=1, PCwrite=1; stallCount unchanged; flushCount+1.
- Memory wait: EX_MEMmemAccess=1, dmemReady=0 for 3 cycles, then 1 → all five enables 0 for 3 cycles, released on the 4th; stallCount +3; state returns to RUN.
- Timeout: TIMEOUT=4, dmemReady held 0 → memError rises after the 4th MEM_WAIT cycle, the pipeline is released and memError stays 1. A later reset clears it.
- Async reset during MEM_WAIT plus counter saturation (CNT_W=2, 5 stall cycles → stallCount=3) → rst_n low mid-wait immediately forces enables to 1 and counters to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: sequencer state encoding, register-zero constant
// and the default performance counter width.
package pipe_pkg;
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         CNT_W_DEF = 16;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, taken-branch
// and multi-cycle data-memory hazards into stage enables, bubbles and flushes.
module pipeline_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EXmemRead,
  input  logic [4:0]       ID_EXrd,
  input  logic [4:0]       IF_IDrs1,
  input  logic [4:0]       IF_IDrs2,
  input  logic             branchTaken,
  input  logic             EX_MEMmemAccess,
  input  logic             dmemReady,
  output logic             PCwrite,
  output logic             IF_IDwrite,
  output logic             IF_IDflush,
  output logic             ID_EXwrite,
  output logic             ID_EXbubble,
  output logic             EX_MEMwrite,
  output logic             MEM_WBwrite,
  output logic             memError,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);
  state_e          state;
  logic [TO_W-1:0] wait_cnt;
  logic            load_use, mem_wait, timed_out, freeze;

  assign load_use  = ID_EXmemRead && (ID_EXrd != REG_ZERO) &&
                     ((ID_EXrd == IF_IDrs1) || (ID_EXrd == IF_IDrs2));
  assign mem_wait  = EX_MEMmemAccess && !dmemReady;
  // On the timeout cycle the stuck access is abandoned and the pipe runs normally.
  assign timed_out = (state == ST_MEM_WAIT) && (wait_cnt == TO_W'(TIMEOUT)) && mem_wait;
  assign freeze    = mem_wait && !timed_out;

  always_comb begin
    PCwrite     = 1'b1;
    IF_IDwrite  = 1'b1;
    IF_IDflush  = 1'b0;
    ID_EXwrite  = 1'b1;
    ID_EXbubble = 1'b0;
    EX_MEMwrite = 1'b1;
    MEM_WBwrite = 1'b1;
    if (freeze) begin
      PCwrite     = 1'b0;
      IF_IDwrite  = 1'b0;
      ID_EXwrite  = 1'b0;
      EX_MEMwrite = 1'b0;
      MEM_WBwrite = 1'b0;
    end else if (branchTaken) begin
      IF_IDflush  = 1'b1;
      ID_EXbubble = 1'b1;
    end else if (load_use) begin
      PCwrite     = 1'b0;
      IF_IDwrite  = 1'b0;
      ID_EXbubble = 1'b1;
    end
  end

  // wait_cnt is 0 in RUN, so entering MEM_WAIT loads 1 via the same increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      memError <= 1'b0;
    end else begin
      if (timed_out)
        memError <= 1'b1;
      if (freeze) begin
        state    <= ST_MEM_WAIT;
        wait_cnt <= wait_cnt + TO_W'(1);
      end else begin
        state    <= ST_RUN;
        wait_cnt <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!PCwrite),
    .count (stallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (IF_IDflush),
    .count (flushCount)
  );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with small counters and a short timeout.
module tb_pipeline_stall_ctrl;
  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;

  // {PCwrite, IF_IDwrite, IF_IDflush, ID_EXwrite, ID_EXbubble, EX_MEMwrite, MEM_WBwrite}
  localparam logic [6:0] EN_RUN = 7'b1101011;
  localparam logic [6:0] EN_FRZ = 7'b0000000;
  localparam logic [6:0] EN_BR  = 7'b1111111;
  localparam logic [6:0] EN_LU  = 7'b0001111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ID_EXmemRead, branchTaken, EX_MEMmemAccess, dmemReady;
  logic [4:0] ID_EXrd, IF_IDrs1, IF_IDrs2;
  logic PCwrite, IF_IDwrite, IF_IDflush, ID_EXwrite, ID_EXbubble, EX_MEMwrite, MEM_WBwrite;
  logic memError;
  logic [CNT_W-1:0] stallCount, flushCount;
  logic [6:0] en;
  int total = 0;
  int bad = 0;

  assign en = {PCwrite, IF_IDwrite, IF_IDflush, ID_EXwrite, ID_EXbubble, EX_MEMwrite, MEM_WBwrite};

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EXmemRead(ID_EXmemRead), .ID_EXrd(ID_EXrd),
    .IF_IDrs1(IF_IDrs1), .IF_IDrs2(IF_IDrs2),
    .branchTaken(branchTaken), .EX_MEMmemAccess(EX_MEMmemAccess), .dmemReady(dmemReady),
    .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite), .IF_IDflush(IF_IDflush),
    .ID_EXwrite(ID_EXwrite), .ID_EXbubble(ID_EXbubble),
    .EX_MEMwrite(EX_MEMwrite), .MEM_WBwrite(MEM_WBwrite),
    .memError(memError), .stallCount(stallCount), .flushCount(flushCount)
  );

  task idle;
    ID_EXmemRead = 1'b0; ID_EXrd = 5'd0; IF_IDrs1 = 5'd0; IF_IDrs2 = 5'd0;
    branchTaken = 1'b0; EX_MEMmemAccess = 1'b0; dmemReady = 1'b1;
  endtask

  task step;
    @(posedge clk); #1;
  endtask

  task do_reset;
    rst_n = 1'b0; idle(); step(); rst_n = 1'b1;
  endtask

  task test_reset;
    idle(); #2 rst_n = 1'b0; #1;
    total++; if (en !== EN_RUN) begin bad++; $display("FAIL rst_en got=%b exp=%b", en, EN_RUN); end
    total++; if (memError !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", memError); end
    total++; if (stallCount !== 2'd0) begin bad++; $display("FAIL rst_stall got=%0d exp=0", stallCount); end
    total++; if (flushCount !== 2'd0) begin bad++; $display("FAIL rst_flush got=%0d exp=0", flushCount); end
    step(); rst_n = 1'b1;
  endtask

  task test_load_use;
    do_reset();
    ID_EXmemRead = 1'b1; ID_EXrd = 5'd5; IF_IDrs2 = 5'd5; #1;
    total++; if (en !== EN_LU) begin bad++; $display("FAIL lu_en got=%b exp=%b", en, EN_LU); end
    step(); idle(); #1;
    total++; if (en !== EN_RUN) begin bad++; $display("FAIL lu_after_en got=%b exp=%b", en, EN_RUN); end
    total++; if (stallCount !== 2'd1) begin bad++; $display("FAIL lu_stall got=%0d exp=1", stallCount); end
    step(); #1;
    total++; if (stallCount !== 2'd1) begin bad++; $display("FAIL lu_stall_hold got=%0d exp=1", stallCount); end
  endtask

  task test_no_stall;
    ID_EXmemRead = 1'b1; ID_EXrd = 5'd0; IF_IDrs1 = 5'd0; IF_IDrs2 = 5'd0; #1;
    total++; if (en !== EN_RUN) begin bad++; $display("FAIL x0_en got=%b exp=%b", en, EN_RUN); end
    ID_EXrd = 5'd7; IF_IDrs1 = 5'd3; IF_IDrs2 = 5'd4; #1;
    total++; if (en !== EN_RUN) begin bad++; $display("FAIL nomatch_en got=%b exp=%b", en, EN_RUN); end
    step(); idle(); #1;
    total++; if (stallCount !== 2'd1) begin bad++; $display("FAIL nostall_cnt got=%0d exp=1", stallCount); end
  endtask

  task test_branch_load_use;
    do_reset();
    ID_EXmemRead = 1'b1; ID_EXrd = 5'd5; IF_IDrs1 = 5'd5; branchTaken = 1'b1; #1;
    total++; if (en !== EN_BR) begin bad++; $display("FAIL br_lu_en got=%b exp=%b", en, EN_BR); end
    step(); idle(); #1;
    total++; if (stallCount !== 2'd0) begin bad++; $display("FAIL br_lu_stall got=%0d exp=0", stallCount); end
    total++; if (flushCount !== 2'd1) begin bad++; $display("FAIL br_lu_flush got=%0d exp=1", flushCount); end
  endtask

  task test_mem_wait;
    do_reset();
    EX_MEMmemAccess = 1'b1; dmemReady = 1'b0; branchTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (en !== EN_FRZ) begin bad++; $display("FAIL mw_freeze%0d got=%b exp=%b", i, en, EN_FRZ); end
      step();
    end
    dmemReady = 1'b1; #1;
    total++; if (en !== EN_BR) begin bad++; $display("FAIL mw_release got=%b exp=%b", en, EN_BR); end
    step(); idle(); #1;
    total++; if (en !== EN_RUN) begin bad++; $display("FAIL mw_run got=%b exp=%b", en, EN_RUN); end
    total++; if (stallCount !== 2'd3) begin bad++; $display("FAIL mw_stall got=%0d exp=3", stallCount); end
    total++; if (flushCount !== 2'd1) begin bad++; $display("FAIL mw_flush got=%0d exp=1", flushCount); end
    EX_MEMmemAccess = 1'b1; dmemReady = 1'b1; #1;
    total++; if (en !== EN_RUN) begin bad++; $display("FAIL mw_ready_hit got=%b exp=%b", en, EN_RUN); end
    step(); idle();
  endtask

  task test_timeout;
    do_reset();
    EX_MEMmemAccess = 1'b1; dmemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (en !== EN_FRZ) begin bad++; $display("FAIL to_freeze%0d got=%b exp=%b", i, en, EN_FRZ); end
      step();
    end
    #1;
    total++; if (en !== EN_RUN) begin bad++; $display("FAIL to_release got=%b exp=%b", en, EN_RUN); end
    total++; if (memError !== 1'b0) begin bad++; $display("FAIL to_err_early got=%b exp=0", memError); end
    step(); idle(); #1;
    total++; if (memError !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", memError); end
    total++; if (stallCount !== 2'd3) begin bad++; $display("FAIL to_stall_sat got=%0d exp=3", stallCount); end
    step(); step(); #1;
    total++; if (memError !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%b exp=1", memError); end
    rst_n = 1'b0; #1;
    total++; if (memError !== 1'b0) begin bad++; $display("FAIL to_err_clr got=%b exp=0", memError); end
    step(); rst_n = 1'b1;
  endtask

  task test_reset_mid_wait;
    do_reset();
    ID_EXmemRead = 1'b1; ID_EXrd = 5'd9; IF_IDrs1 = 5'd9;
    step(); step(); idle();
    EX_MEMmemAccess = 1'b1; dmemReady = 1'b0;
    step(); step(); step(); #1;
    total++; if (stallCount !== 2'd3) begin bad++; $display("FAIL rmw_sat got=%0d exp=3", stallCount); end
    total++; if (en !== EN_FRZ) begin bad++; $display("FAIL rmw_frozen got=%b exp=%b", en, EN_FRZ); end
    rst_n = 1'b0; EX_MEMmemAccess = 1'b0; #1;
    total++; if (en !== EN_RUN) begin bad++; $display("FAIL rmw_en got=%b exp=%b", en, EN_RUN); end
    total++; if (stallCount !== 2'd0) begin bad++; $display("FAIL rmw_stall got=%0d exp=0", stallCount); end
    total++; if (flushCount !== 2'd0) begin bad++; $display("FAIL rmw_flush got=%0d exp=0", flushCount); end
    step(); rst_n = 1'b1;
    // A fresh wait must again last the full timeout, proving the wait count was cleared.
    EX_MEMmemAccess = 1'b1; dmemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (en !== EN_FRZ) begin bad++; $display("FAIL rmw_refreeze%0d got=%b exp=%b", i, en, EN_FRZ); end
      step();
    end
    #1;
    total++; if (en !== EN_RUN) begin bad++; $display("FAIL rmw_rerelease got=%b exp=%b", en, EN_RUN); end
    step(); idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
